// File: rtl/cp0_unit_pkg.sv
// ============================================================================
// Module      : cp0_unit_pkg
// Description : Shared CP0 register numbers, ExcCode values and field layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

    localparam logic [4:0] C_CP0_BADVADDR = 5'd8;
    localparam logic [4:0] C_CP0_SR       = 5'd12;
    localparam logic [4:0] C_CP0_CAUSE    = 5'd13;
    localparam logic [4:0] C_CP0_EPC      = 5'd14;
    localparam logic [4:0] C_CP0_PRID     = 5'd15;

    localparam logic [4:0] C_EXC_INT  = 5'd0;
    localparam logic [4:0] C_EXC_ADEL = 5'd4;
    localparam logic [4:0] C_EXC_ADES = 5'd5;
    localparam logic [4:0] C_EXC_RI   = 5'd10;
    localparam logic [4:0] C_EXC_OV   = 5'd12;

    localparam int C_SR_IE       = 0;
    localparam int C_SR_EXL      = 1;
    localparam int C_SR_IM_LO    = 10;
    localparam int C_SR_IM_HI    = 15;
    localparam int C_CAUSE_EXC_LO = 2;
    localparam int C_CAUSE_EXC_HI = 6;
    localparam int C_CAUSE_IP_LO  = 10;
    localparam int C_CAUSE_IP_HI  = 15;
    localparam int C_CAUSE_BD     = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    function automatic logic [31:0] sr_pack(input sr_t s);
        logic [31:0] v;
        v                        = '0;
        v[C_SR_IM_HI:C_SR_IM_LO] = s.im;
        v[C_SR_EXL]              = s.exl;
        v[C_SR_IE]               = s.ie;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_unit_sync2.sv
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for asynchronous level inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module      : cp0_unit
// Description : MIPS-style CP0 (SR/Cause/EPC/PRId), exception entry and eret.
//               Optional BadVAddr register enabled by CP0_BADVADDR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL  = 32'h0000_0018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcM,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic        bdM,
    input  logic [5:0]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] badvaddr,
`endif
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        npc_sel,
    output logic [31:0] npc,
    output logic        exl
);

    sr_t         r_sr;
    logic        r_bd;
    logic [4:0]  r_exc_code;
    logic [29:0] r_epc;
    logic [5:0]  w_ip;

    logic        w_int_req;
    logic        w_take_int;
    logic        w_take_exc;
    logic        w_enter;
    logic        w_do_eret;
    logic        w_do_mtc0;
    logic [31:0] w_pc_epc;
    logic [31:0] w_epc_val;
    logic        w_unused;

    // Cause.IP is the synchronizer output itself, giving two cycles hwint->IP
    sync2 #(.WIDTH(6)) u_sync_hwint (
        .clk     (clk),
        .rst     (rst),
        .i_async (hwint),
        .o_sync  (w_ip)
    );

    assign w_int_req  = r_sr.ie & ~r_sr.exl & (|(w_ip & r_sr.im));
    assign w_take_int = ~rst & w_int_req;
    assign w_take_exc = ~rst & exc_valid & ~r_sr.exl & ~w_int_req;
    assign w_enter    = w_take_int | w_take_exc;
    assign w_do_eret  = ~rst & eret & ~w_enter;
    assign w_do_mtc0  = ~rst & cp0_we & ~w_enter & ~eret;

    assign w_pc_epc  = bdM ? (pcM - 32'd4) : pcM;
    assign w_epc_val = {r_epc, 2'b00};
    assign w_unused  = ^w_pc_epc[1:0];

    assign flush   = w_enter | w_do_eret;
    assign npc_sel = w_enter | w_do_eret;
    assign npc     = w_enter ? EXC_ENTRY : w_epc_val;
    assign exl     = r_sr.exl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_bd       <= 1'b0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else if (w_enter) begin
            r_sr.exl   <= 1'b1;
            r_bd       <= bdM;
            r_exc_code <= w_take_int ? C_EXC_INT : exc_code;
            r_epc      <= w_pc_epc[31:2];
        end else if (w_do_eret) begin
            r_sr.exl   <= 1'b0;
        end else if (w_do_mtc0) begin
            case (cp0_addr)
                C_CP0_SR: begin
                    r_sr.im  <= cp0_wdata[C_SR_IM_HI:C_SR_IM_LO];
                    r_sr.exl <= cp0_wdata[C_SR_EXL];
                    r_sr.ie  <= cp0_wdata[C_SR_IE];
                end
                C_CP0_EPC: r_epc <= cp0_wdata[31:2];
                default:   ;
            endcase
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr <= '0;
        end else if (w_take_exc && (exc_code == C_EXC_ADEL || exc_code == C_EXC_ADES)) begin
            r_badvaddr <= badvaddr;
        end
    end
`endif

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            C_CP0_SR: cp0_rdata = sr_pack(r_sr);
            C_CP0_CAUSE: begin
                cp0_rdata[C_CAUSE_BD]                     = r_bd;
                cp0_rdata[C_CAUSE_IP_HI:C_CAUSE_IP_LO]    = w_ip;
                cp0_rdata[C_CAUSE_EXC_HI:C_CAUSE_EXC_LO]  = r_exc_code;
            end
            C_CP0_EPC:  cp0_rdata = w_epc_val;
            C_CP0_PRID: cp0_rdata = PRID_VAL;
`ifdef CP0_BADVADDR_EN
            C_CP0_BADVADDR: cp0_rdata = r_badvaddr;
`endif
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// ============================================================================
// Module      : tb_cp0_unit
// Description : Directed plus randomized checks of cp0_unit against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcM;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        bdM;
    logic [5:0]  hwint;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        npc_sel;
    logic [31:0] npc;
    logic        exl;
`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr = 32'h0;
`endif

    int checks = 0;
    int errors = 0;

    // architectural model state
    logic [5:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [5:0]  m_h1, m_h2;

    logic [31:0] last_rdata, last_npc;
    logic        last_flush, last_exl;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk       (clk),
        .rst       (rst),
        .pcM       (pcM),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .bdM       (bdM),
        .hwint     (hwint),
        .cp0_we    (cp0_we),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .eret      (eret),
`ifdef CP0_BADVADDR_EN
        .badvaddr  (badvaddr),
`endif
        .cp0_rdata (cp0_rdata),
        .flush     (flush),
        .npc_sel   (npc_sel),
        .npc       (npc),
        .exl       (exl)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {16'b0, m_im, 8'b0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'b0, m_h2, 3'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0018;
            default: return 32'h0;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic [31:0] pc, input logic ev,
                         input logic [4:0] ec, input logic bd, input logic [5:0] hw,
                         input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic er);
        logic intr, ent, der, dwe;
        @(negedge clk);
        rst = r; pcM = pc; exc_valid = ev; exc_code = ec; bdM = bd; hwint = hw;
        cp0_we = we; cp0_addr = a; cp0_wdata = wd; eret = er;
        #1;
        intr = m_ie && !m_exl && ((m_h2 & m_im) != 6'd0);
        ent  = !r && (intr || (ev && !m_exl));
        der  = !r && er && !ent;
        dwe  = !r && we && !ent && !er;
        check_val("rdata", cp0_rdata, m_read(a));
        check_val("flush", {31'b0, flush}, {31'b0, ent || der});
        check_val("npc_sel", {31'b0, npc_sel}, {31'b0, ent || der});
        check_val("npc", npc, ent ? 32'h0000_4180 : m_epc);
        check_val("exl", {31'b0, exl}, {31'b0, m_exl});
        last_rdata = cp0_rdata; last_npc = npc; last_flush = flush; last_exl = exl;
        @(posedge clk);
        if (r) begin
            m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = '0; m_epc = '0;
            m_h1 = '0; m_h2 = '0;
        end else begin
            m_h2 = m_h1;
            m_h1 = hw;
            if (ent) begin
                m_exl  = 1'b1;
                m_bd   = bd;
                m_code = intr ? 5'd0 : ec;
                m_epc  = (bd ? pc - 32'd4 : pc) & ~32'd3;
            end else if (der) begin
                m_exl = 1'b0;
            end else if (dwe) begin
                if (a == 5'd12) begin
                    m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0];
                end else if (a == 5'd14) begin
                    m_epc = wd & ~32'd3;
                end
            end
        end
    endtask

    task automatic idle(input logic [4:0] a, input logic [5:0] hw);
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, hw, 1'b0, a, 32'h0, 1'b0);
    endtask

    initial begin
        logic [5:0] hw_cur;
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = '0; m_epc = '0;
        m_h1 = '0; m_h2 = '0;

        // reset state
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b0);
        idle(5'd12, 6'd0); check_val("rst_sr", last_rdata, 32'h0);
        check_val("rst_exl", {31'b0, last_exl}, 32'h0);
        check_val("rst_flush", {31'b0, last_flush}, 32'h0);
        idle(5'd13, 6'd0); check_val("rst_cause", last_rdata, 32'h0);
        idle(5'd14, 6'd0); check_val("rst_epc", last_rdata, 32'h0);

        // EPC low bits masked, PRId constant
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd14, 32'h0000_3003, 1'b0);
        idle(5'd14, 6'd0); check_val("epc_mask", last_rdata, 32'h0000_3000);
        idle(5'd15, 6'd0); check_val("prid", last_rdata, 32'h0000_0018);

        // overflow in a delay slot
        cycle(1'b0, 32'h3008, 1'b1, 5'd12, 1'b1, 6'd0, 1'b0, 5'd13, 32'h0, 1'b0);
        check_val("ov_flush", {31'b0, last_flush}, 32'h1);
        check_val("ov_npc", last_npc, 32'h0000_4180);
        idle(5'd14, 6'd0); check_val("ov_epc", last_rdata, 32'h0000_3004);
        check_val("ov_flush_once", {31'b0, last_flush}, 32'h0);
        idle(5'd13, 6'd0); check_val("ov_cause", last_rdata, 32'h8000_0030);

        // exception ignored under EXL, then eret
        cycle(1'b0, 32'h5000, 1'b1, 5'd4, 1'b0, 6'd0, 1'b0, 5'd14, 32'h0, 1'b0);
        check_val("exl_ign_flush", {31'b0, last_flush}, 32'h0);
        idle(5'd14, 6'd0); check_val("exl_ign_epc", last_rdata, 32'h0000_3004);
        idle(5'd13, 6'd0); check_val("exl_ign_cause", last_rdata, 32'h8000_0030);
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b1);
        check_val("eret_flush", {31'b0, last_flush}, 32'h1);
        check_val("eret_npc", last_npc, 32'h0000_3004);
        idle(5'd12, 6'd0); check_val("eret_exl", {31'b0, last_exl}, 32'h0);

        // mtc0 to EPC dropped by a same-cycle exception
        cycle(1'b0, 32'h2000, 1'b1, 5'd10, 1'b0, 6'd0, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0);
        idle(5'd14, 6'd0); check_val("mtc0_drop", last_rdata, 32'h0000_2000);
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b1);

        // hardware interrupt through the synchronizer
        cycle(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
        cycle(1'b0, 32'h1234_5670, 1'b0, 5'd0, 1'b0, 6'd1, 1'b0, 5'd12, 32'h0, 1'b0);
        check_val("int_c0", {31'b0, last_flush}, 32'h0);
        cycle(1'b0, 32'h1234_5670, 1'b0, 5'd0, 1'b0, 6'd1, 1'b0, 5'd12, 32'h0, 1'b0);
        check_val("int_c1", {31'b0, last_flush}, 32'h0);
        cycle(1'b0, 32'h1234_5670, 1'b0, 5'd0, 1'b0, 6'd1, 1'b0, 5'd12, 32'h0, 1'b0);
        check_val("int_c2", {31'b0, last_flush}, 32'h1);
        check_val("int_npc", last_npc, 32'h0000_4180);
        idle(5'd14, 6'd0); check_val("int_epc", last_rdata, 32'h1234_5670);
        check_val("int_exl", {31'b0, last_exl}, 32'h1);
        idle(5'd13, 6'd0); check_val("int_code", {27'b0, last_rdata[6:2]}, 32'h0);
        cycle(1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b0);

        // randomized traffic against the model
        hw_cur = 6'd0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, wd;
            logic [4:0]  a;
            if ($urandom_range(0, 15) == 0) hw_cur = 6'($urandom);
            pc = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom & ~32'd3);
            case ($urandom_range(0, 6))
                0: a = 5'd8;
                1: a = 5'd12;
                2: a = 5'd13;
                3: a = 5'd14;
                4: a = 5'd15;
                default: a = 5'($urandom);
            endcase
            wd = $urandom;
            if (a == 5'd12 && $urandom_range(0, 1) == 1) wd[1] = 1'b0;
            cycle($urandom_range(0, 63) == 0, pc, $urandom_range(0, 5) == 0,
                  5'($urandom), 1'($urandom), hw_cur, $urandom_range(0, 3) == 0,
                  a, wd, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
